// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types; ramstate_t is the memory responder status seen by the controller.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

endpackage

// File: rtl/ram_responder_if.sv
// Controller-to-RAM request/response bundle; master drives requests, slave answers.
interface ram_responder_if;
    import cpu_types_pkg::*;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM model with programmable BUSY latency, request-change abort and
// illegal-request fault reporting.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 1024
) (
    input logic            CLK,
    input logic            RST,
    ram_responder_if.slave bus
);

    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LatCnt = 4'(LAT);

    typedef enum logic [1:0] {StIdle, StWait, StDone, StFault} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ren_q, ren_d, wen_q, wen_d;
    logic [31:0] addr_q, addr_d, store_q, store_d;

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] widx;

    logic       req_any, req_legal, req_changed;
    state_e     start_state;
    logic [3:0] start_cnt;

    assign widx    = addr_q[AW+1:2];
    assign req_any = bus.ramREN | bus.ramWEN;
    assign req_legal = !(bus.ramREN && bus.ramWEN) && (bus.ramaddr[1:0] == 2'b00)
                       && ({2'b00, bus.ramaddr[31:2]} < 32'(DEPTH));
    assign req_changed = (bus.ramREN != ren_q) || (bus.ramWEN != wen_q)
                         || (bus.ramaddr != addr_q) || (bus.ramstore != store_q);

    // Where a freshly sampled request leads, shared by IDLE, WAIT-abort and FAULT-change.
    always_comb begin
        start_state = StIdle;
        start_cnt   = 4'd0;
        if (!req_any) begin
            start_state = StIdle;
        end else if (!req_legal) begin
            start_state = StFault;
        end else if (LAT == 0) begin
            start_state = StDone;
        end else begin
            start_state = StWait;
            start_cnt   = LatCnt;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        store_d = store_q;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    state_d = start_state;
                    cnt_d   = start_cnt;
                    ren_d   = bus.ramREN;
                    wen_d   = bus.ramWEN;
                    addr_d  = bus.ramaddr;
                    store_d = bus.ramstore;
                end
            end
            StWait, StFault: begin
                if (req_changed) begin
                    state_d = start_state;
                    cnt_d   = start_cnt;
                    ren_d   = bus.ramREN;
                    wen_d   = bus.ramWEN;
                    addr_d  = bus.ramaddr;
                    store_d = bus.ramstore;
                end else if (state_q == StWait) begin
                    if (cnt_q == 4'd1) state_d = StDone;
                    cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= 32'h0;
            store_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            store_q <= store_d;
        end
    end

    // Storage is not reset; a write pending at a reset edge is dropped.
    always_ff @(posedge CLK) begin
        if (!RST && state_q == StDone && wen_q) begin
            mem[widx] <= store_q;
        end
    end

    always_comb begin
        bus.ramstate = FREE;
        unique case (state_q)
            StIdle:  bus.ramstate = FREE;
            StWait:  bus.ramstate = BUSY;
            StDone:  bus.ramstate = ACCESS;
            StFault: bus.ramstate = ERROR;
            default: bus.ramstate = FREE;
        endcase
    end

    always_comb begin
        bus.ramload = 32'h0;
        if (state_q == StDone && ren_q) bus.ramload = mem[widx];
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed plus randomized bench for ram_responder with LAT=2 and LAT=0 instances.
module tb_ram_responder;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    ram_responder_if bus_a ();
    ram_responder_if bus_b ();

    ram_responder #(.LAT(2), .DEPTH(1024)) dut_a (.CLK(CLK), .RST(RST), .bus(bus_a.slave));
    ram_responder #(.LAT(0), .DEPTH(1024)) dut_b (.CLK(CLK), .RST(RST), .bus(bus_b.slave));

    int checks = 0;
    int errors = 0;
    logic [31:0] model [2][1024];

    function automatic int lat_of(int s);
        return (s == 0) ? 2 : 0;
    endfunction

    function automatic ramstate_t st(int s);
        return (s == 0) ? bus_a.ramstate : bus_b.ramstate;
    endfunction

    function automatic logic [31:0] ld(int s);
        return (s == 0) ? bus_a.ramload : bus_b.ramload;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(int s, logic ren, logic wen, logic [31:0] a, logic [31:0] d);
        if (s == 0) begin
            bus_a.ramREN = ren; bus_a.ramWEN = wen; bus_a.ramaddr = a; bus_a.ramstore = d;
        end else begin
            bus_b.ramREN = ren; bus_b.ramWEN = wen; bus_b.ramaddr = a; bus_b.ramstore = d;
        end
    endtask

    task automatic chk_st(string tag, ramstate_t o, ramstate_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: state got %s want %s", tag, o.name(), e.name());
        end
    endtask

    task automatic chk_ld(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: ramload got %h want %h", tag, o, e);
        end
    endtask

    // One full legal transaction: expected timing is LAT BUSY cycles then one ACCESS.
    task automatic xact(int s, logic ren, logic wen, logic [31:0] a, logic [31:0] d,
                        bit hold, ramstate_t first);
        logic [31:0] exp_ld;
        drive(s, ren, wen, a, d);
        chk_st($sformatf("start%0d@%h", s, a), st(s), first);
        for (int k = 0; k < lat_of(s); k++) begin
            tick();
            chk_st($sformatf("busy%0d@%h", s, a), st(s), BUSY);
            chk_ld($sformatf("busy_load%0d@%h", s, a), ld(s), 32'h0);
        end
        tick();
        chk_st($sformatf("access%0d@%h", s, a), st(s), ACCESS);
        exp_ld = ren ? model[s][a[11:2]] : 32'h0;
        chk_ld($sformatf("access_load%0d@%h", s, a), ld(s), exp_ld);
        if (wen) model[s][a[11:2]] = d;
        if (!hold) drive(s, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk_st($sformatf("free%0d@%h", s, a), st(s), FREE);
        chk_ld($sformatf("free_load%0d@%h", s, a), ld(s), 32'h0);
    endtask

    task automatic ill(int s, logic ren, logic wen, logic [31:0] a, logic [31:0] d);
        drive(s, ren, wen, a, d);
        chk_st($sformatf("ill_start@%h", a), st(s), FREE);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_st($sformatf("ill_err@%h", a), st(s), ERROR);
            chk_ld($sformatf("ill_load@%h", a), ld(s), 32'h0);
        end
        drive(s, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk_st($sformatf("ill_free@%h", a), st(s), FREE);
    endtask

    initial begin
        logic [31:0] a, d;
        logic        op;
        bit          hold;

        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        RST = 1'b1;
        tick();
        tick();
        chk_st("rst_a", st(0), FREE);
        chk_ld("rst_load_a", ld(0), 32'h0);
        chk_st("rst_b", st(1), FREE);
        RST = 1'b0;

        // Preload words later used to prove nothing else was touched.
        xact(0, 1'b0, 1'b1, 32'h0,  32'h0BADF00D, 1'b0, FREE);
        xact(0, 1'b0, 1'b1, 32'h80, 32'hA5A50080, 1'b0, FREE);
        xact(0, 1'b0, 1'b1, 32'h84, 32'hA5A50084, 1'b0, FREE);

        xact(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, FREE);
        xact(0, 1'b1, 1'b0, 32'h40, 32'h0,        1'b0, FREE);

        // Address change during BUSY restarts the count and retargets the write.
        drive(0, 1'b0, 1'b1, 32'h80, 32'h11111111);
        chk_st("abort_start", st(0), FREE);
        tick();
        chk_st("abort_busy0", st(0), BUSY);
        drive(0, 1'b0, 1'b1, 32'h84, 32'h11111111);
        tick();
        chk_st("abort_busy1", st(0), BUSY);
        tick();
        chk_st("abort_busy2", st(0), BUSY);
        tick();
        chk_st("abort_access", st(0), ACCESS);
        model[0][32'h84 >> 2] = 32'h11111111;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk_st("abort_free", st(0), FREE);
        xact(0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, FREE);
        xact(0, 1'b1, 1'b0, 32'h84, 32'h0, 1'b0, FREE);

        ill(0, 1'b1, 1'b1, 32'h40,   32'h55555555);
        ill(0, 1'b0, 1'b1, 32'h42,   32'h66666666);
        ill(0, 1'b0, 1'b1, 32'h1000, 32'h77777777);
        xact(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, FREE);
        xact(0, 1'b1, 1'b0, 32'h0,  32'h0, 1'b0, FREE);

        // Changing an illegal request to a legal one starts a fresh transaction.
        drive(0, 1'b1, 1'b0, 32'h42, 32'h0);
        tick();
        chk_st("fault_hold", st(0), ERROR);
        xact(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, ERROR);

        // Back-to-back: read held into the FREE cycle, then switched to a write.
        xact(0, 1'b1, 1'b0, 32'h40, 32'h0,        1'b1, FREE);
        xact(0, 1'b0, 1'b1, 32'h44, 32'hCAFEF00D, 1'b0, FREE);
        xact(0, 1'b1, 1'b0, 32'h44, 32'h0,        1'b0, FREE);

        // Reset during BUSY drops the write.
        drive(0, 1'b0, 1'b1, 32'h40, 32'h12345678);
        chk_st("rst_wr_start", st(0), FREE);
        tick();
        chk_st("rst_wr_busy", st(0), BUSY);
        RST = 1'b1;
        tick();
        chk_st("rst_wr_free", st(0), FREE);
        RST = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk_st("rst_wr_idle", st(0), FREE);
        xact(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, FREE);

        // LAT=0 instance: ACCESS on the second cycle of the request.
        xact(1, 1'b0, 1'b1, 32'h40, 32'h0BEEF040, 1'b0, FREE);
        xact(1, 1'b1, 1'b0, 32'h40, 32'h0,        1'b0, FREE);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                xact(s, 1'b0, 1'b1, 32'h200 + 32'(i) * 4, $urandom, 1'b0, FREE);
            end
            for (int i = 0; i < 40; i++) begin
                a    = 32'h200 + 32'($urandom_range(0, 15)) * 4;
                d    = $urandom;
                op   = 1'($urandom_range(0, 1));
                hold = (i != 39) && ($urandom_range(0, 1) == 1);
                xact(s, op, ~op, a, d, hold, FREE);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
